// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: qualifies raw PLL lock, sequences the downstream
// system reset, generates per-channel divided clock-enables and counts
// lock-loss events. Single clock domain (clock_in).
module pll_lock_supervisor #(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned NUM_CH             = 2,
    parameter int unsigned DIV_W              = 8,
    parameter int unsigned CNT_W              = 8
) (
    input  logic                      clock_in,
    input  logic                      resetb,
    input  logic                      locked_in,
    input  logic [NUM_CH*DIV_W-1:0]   div_ratio,
    input  logic                      clear_flags,
    output logic                      sys_reset_n,
    output logic                      ready,
    output logic [NUM_CH-1:0]         ce_out,
    output logic                      lock_lost,
    output logic [CNT_W-1:0]          loss_count
);

    localparam int unsigned STAB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } state_e;

    state_e                         state_q, state_d;
    logic                           sync1_q, sync2_q;
    logic [STAB_W-1:0]              stab_q, stab_d;
    logic                           sys_reset_n_q, sys_reset_n_d;
    logic                           ready_q, ready_d;
    logic                           lost_q, lost_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [NUM_CH-1:0][DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [NUM_CH-1:0][DIV_W-1:0]   dlat_q, dlat_d;
    logic [NUM_CH-1:0][DIV_W-1:0]   deff;
    logic [NUM_CH-1:0]              ce_q, ce_d;
    logic                           locked_s;
    logic                           loss_event;
    logic                           enter_run;
    logic                           stay_run;

    assign locked_s = sync2_q;

    // Two-flop synchroniser for the asynchronous lock flag
    always_ff @(posedge clock_in or negedge resetb) begin
        if (!resetb) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= locked_in;
            sync2_q <= sync1_q;
        end
    end

    // State and output registers
    always_ff @(posedge clock_in or negedge resetb) begin
        if (!resetb) begin
            state_q       <= WAIT_LOCK;
            stab_q        <= '0;
            sys_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
            lost_q        <= 1'b0;
            cnt_q         <= '0;
            div_cnt_q     <= '0;
            dlat_q        <= '0;
            ce_q          <= '0;
        end else begin
            state_q       <= state_d;
            stab_q        <= stab_d;
            sys_reset_n_q <= sys_reset_n_d;
            ready_q       <= ready_d;
            lost_q        <= lost_d;
            cnt_q         <= cnt_d;
            div_cnt_q     <= div_cnt_d;
            dlat_q        <= dlat_d;
            ce_q          <= ce_d;
        end
    end

    // Lock qualification FSM; reset/ready follow the next state so they switch with it
    always_comb begin
        state_d    = state_q;
        stab_d     = stab_q;
        loss_event = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                    stab_d  = '0;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (stab_q == STAB_LAST) begin
                    state_d = RUN;
                end else begin
                    stab_d = stab_q + STAB_ONE;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d    = WAIT_LOCK;
                    loss_event = 1'b1;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
        sys_reset_n_d = (state_d == RUN);
        ready_d       = (state_d == RUN);
    end

    // Sticky loss flag and saturating loss counter; a loss beats a same-edge clear
    always_comb begin
        lost_d = lost_q;
        cnt_d  = cnt_q;
        if (loss_event) begin
            lost_d = 1'b1;
            if (clear_flags) begin
                cnt_d = CNT_ONE;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (clear_flags) begin
            lost_d = 1'b0;
            cnt_d  = '0;
        end
    end

    // Per-channel dividers; divisor is latched at RUN entry and at each wrap only
    always_comb begin
        enter_run = (state_d == RUN) && (state_q != RUN);
        stay_run  = (state_d == RUN) && (state_q == RUN);
        deff      = '0;
        div_cnt_d = '0;
        dlat_d    = dlat_q;
        ce_d      = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            deff[k] = (div_ratio[k*DIV_W +: DIV_W] == '0) ? DIV_ONE : div_ratio[k*DIV_W +: DIV_W];
            if (enter_run || (stay_run && (div_cnt_q[k] == dlat_q[k] - DIV_ONE))) begin
                div_cnt_d[k] = '0;
                dlat_d[k]    = deff[k];
                ce_d[k]      = (deff[k] == DIV_ONE);
            end else if (stay_run) begin
                div_cnt_d[k] = div_cnt_q[k] + DIV_ONE;
                ce_d[k]      = ((div_cnt_q[k] + DIV_ONE) == (dlat_q[k] - DIV_ONE));
            end
        end
    end

    assign sys_reset_n = sys_reset_n_q;
    assign ready       = ready_q;
    assign ce_out      = ce_q;
    assign lock_lost   = lost_q;
    assign loss_count  = cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios plus
// randomized lock/divider/clear/reset traffic against a behavioural model.
module tb_pll_lock_supervisor;

    localparam int L   = 16;
    localparam int NCH = 2;
    localparam int DW  = 8;
    localparam int CW  = 8;

    logic                clk = 1'b0;
    logic                resetb;
    logic                locked_in;
    logic [NCH*DW-1:0]   div_ratio;
    logic                clear_flags;
    logic                sys_reset_n;
    logic                ready;
    logic [NCH-1:0]      ce_out;
    logic                lock_lost;
    logic [CW-1:0]       loss_count;

    pll_lock_supervisor #(
        .LOCK_STABLE_CYCLES(L),
        .NUM_CH(NCH),
        .DIV_W(DW),
        .CNT_W(CW)
    ) dut (
        .clock_in   (clk),
        .resetb     (resetb),
        .locked_in  (locked_in),
        .div_ratio  (div_ratio),
        .clear_flags(clear_flags),
        .sys_reset_n(sys_reset_n),
        .ready      (ready),
        .ce_out     (ce_out),
        .lock_lost  (lock_lost),
        .loss_count (loss_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    bit lq[$];          // locked_in samples still travelling through the synchroniser
    int streak;         // consecutive edges the supervisor has seen lock high
    bit m_ready;
    int rc;             // RUN cycle number of the current cycle (1-based), 0 outside RUN
    int next_at[NCH];   // RUN cycle number of the next strobe per channel
    bit m_lost;
    int m_cnt;

    function automatic int deff(input int k);
        int d;
        d = int'(div_ratio[k*DW +: DW]);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic bit model_ce(input int k);
        return m_ready && (rc == next_at[k]);
    endfunction

    task automatic model_reset();
        lq = {};
        lq.push_back(1'b0);
        lq.push_back(1'b0);
        streak  = 0;
        m_ready = 1'b0;
        rc      = 0;
        for (int k = 0; k < NCH; k++) next_at[k] = 0;
        m_lost  = 1'b0;
        m_cnt   = 0;
    endtask

    // Advance the model by one rising edge using the inputs present at that edge
    task automatic model_edge();
        bit seen;
        bit old_ready;
        int old_rc;
        bit loss;
        if (!resetb) begin
            model_reset();
            return;
        end
        seen = lq.pop_front();
        lq.push_back(locked_in);
        streak    = seen ? streak + 1 : 0;
        old_ready = m_ready;
        old_rc    = rc;
        m_ready   = (streak >= L + 1);
        loss      = old_ready && !m_ready;
        if (m_ready) begin
            if (!old_ready) begin
                rc = 1;
                for (int k = 0; k < NCH; k++) next_at[k] = deff(k);
            end else begin
                for (int k = 0; k < NCH; k++)
                    if (old_rc == next_at[k]) next_at[k] = old_rc + deff(k);
                rc = old_rc + 1;
            end
        end else begin
            rc = 0;
        end
        if (loss) begin
            m_lost = 1'b1;
            m_cnt  = clear_flags ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        end else if (clear_flags) begin
            m_lost = 1'b0;
            m_cnt  = 0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("sys_reset_n", 32'(sys_reset_n), 32'(m_ready));
        chk("ready",       32'(ready),       32'(m_ready));
        for (int k = 0; k < NCH; k++)
            chk($sformatf("ce_out[%0d]", k), 32'(ce_out[k]), 32'(model_ce(k)));
        chk("lock_lost",   32'(lock_lost),   32'(m_lost));
        chk("loss_count",  32'(loss_count),  32'(m_cnt));
    endtask

    // One clock: edge, model update, then compare 1 time unit later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Step until ready reaches want; returns edges taken
    task automatic run_until(input bit want, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (ready !== want && n < limit);
        if (ready !== want) chk("wait_timeout", 32'(ready), 32'(want));
    endtask

    initial begin
        int n;
        int strobes[$];
        int exp_strobes[4] = '{4, 8, 11, 14};

        resetb      = 1'b0;
        locked_in   = 1'b0;
        clear_flags = 1'b0;
        div_ratio   = {8'd0, 8'd4};
        model_reset();
        #12;
        compare_all();
        chk("reset_sys_reset_n", 32'(sys_reset_n), 32'd0);
        chk("reset_loss_count",  32'(loss_count),  32'd0);
        resetb = 1'b1;
        repeat (3) step();

        // Release latency and divided enables with a mid-period divisor change
        locked_in = 1'b1;
        run_until(1'b1, 100, n);
        chk("release_edges", 32'(n), 32'd19);
        chk("release_lock_lost", 32'(lock_lost), 32'd0);
        for (int c = 1; c <= 15; c++) begin
            if (ce_out[0]) strobes.push_back(c);
            chk("ce1_continuous", 32'(ce_out[1]), 32'd1);
            if (c == 6) div_ratio[DW-1:0] = 8'd3;
            step();
        end
        chk("ce0_strobe_count", 32'(strobes.size()), 32'd4);
        for (int i = 0; i < 4 && i < strobes.size(); i++)
            chk("ce0_strobe_cycle", 32'(strobes[i]), 32'(exp_strobes[i]));

        // Loss of lock in RUN
        locked_in = 1'b0;
        run_until(1'b0, 20, n);
        chk("loss_edges", 32'(n), 32'd3);
        chk("loss_ce", 32'(ce_out), 32'd0);
        chk("loss_lock_lost", 32'(lock_lost), 32'd1);
        chk("loss_count_1", 32'(loss_count), 32'd1);

        // clear_flags alone
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("clear_lock_lost", 32'(lock_lost), 32'd0);
        chk("clear_loss_count", 32'(loss_count), 32'd0);

        // Glitch during STABLE at stab_cnt = 10
        locked_in = 1'b1;
        repeat (13) step();
        locked_in = 1'b0;
        repeat (3) step();
        locked_in = 1'b1;
        run_until(1'b1, 100, n);
        chk("glitch_release_edges", 32'(n), 32'd19);
        chk("glitch_loss_count", 32'(loss_count), 32'd0);

        // Loss coinciding with clear_flags: loss wins
        locked_in = 1'b0;
        run_until(1'b0, 20, n);
        locked_in = 1'b1;
        run_until(1'b1, 100, n);
        locked_in = 1'b0;
        repeat (2) step();
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("loss_clear_lock_lost", 32'(lock_lost), 32'd1);
        chk("loss_clear_count", 32'(loss_count), 32'd1);

        // Saturation of the loss counter
        for (int i = 0; i < 300; i++) begin
            locked_in = 1'b1;
            run_until(1'b1, 40, n);
            locked_in = 1'b0;
            run_until(1'b0, 10, n);
        end
        chk("loss_saturated", 32'(loss_count), 32'd255);

        // Asynchronous reset mid-RUN, then full requalification
        locked_in = 1'b1;
        run_until(1'b1, 40, n);
        step();
        #2;
        resetb = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("async_rst_ready", 32'(ready), 32'd0);
        chk("async_rst_loss_count", 32'(loss_count), 32'd0);
        repeat (2) step();
        resetb = 1'b1;
        run_until(1'b1, 100, n);
        chk("post_reset_release_edges", 32'(n), 32'd19);

        // Randomized traffic
        for (int i = 0; i < 5000; i++) begin
            if (locked_in) begin
                if ($urandom_range(0, 79) == 0) locked_in = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                locked_in = 1'b1;
            end
            if ($urandom_range(0, 15) == 0)
                div_ratio[$urandom_range(0, NCH-1)*DW +: DW] = 8'($urandom_range(0, 6));
            clear_flags = ($urandom_range(0, 19) == 0);
            if (resetb && $urandom_range(0, 999) == 0) begin
                #2;
                resetb = 1'b0;
                #1;
                model_reset();
                compare_all();
            end else if (!resetb && $urandom_range(0, 3) == 0) begin
                resetb = 1'b1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
